bar_unit: RTL and testbench
===========================

# bar_unit

Execute-stage barrier engine that carries out the `BAR_DBAR` / `BAR_IBAR` operations produced by the instruction decode path. It accepts one barrier at a time, stalls the issue pipeline until the memory subsystem is drained, and, for IBAR, performs an instruction-side flush and re-fetch redirect before retiring the barrier. It sits between issue and the LSU/fetch control, alongside the other execute units.

## Interface

Parameters:
- `OUTST_W`, 4: width of the outstanding-load counter; up to 2^OUTST_W-1 loads in flight.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `issue_valid` in 1: a barrier op is presented.
- `issue_ready` out 1: the unit can accept; high only in IDLE.
- `bar_op_type` in 2: `BAR_DBAR`, `BAR_IBAR` or `INVALID_OP_2B` (encodings from `defs.sv`).
- `bar_hint` in 15: instr[14:0] hint field.
- `bar_pc` in 32: PC of the barrier instruction.
- `ld_req_fire` in 1: LSU issued a load to memory this cycle.
- `ld_resp_fire` in 1: a load response returned this cycle.
- `sb_empty` in 1: store buffer holds no uncommitted stores.
- `flush_req` out 1: request for I-cache invalidate plus fetch-queue flush.
- `flush_ack` in 1: flush complete, one-cycle pulse.
- `stall` out 1: hold issue; high in every state except IDLE.
- `done` out 1: one-cycle pulse, barrier retired.
- `redirect_valid` out 1: one-cycle pulse, refetch from `redirect_pc`.
- `redirect_pc` out 32: `bar_pc + 4`, valid with `redirect_valid`.
- `ine_exc` out 1: one-cycle pulse, invalid op accepted.

## Operation

- States: IDLE, DRAIN, FLUSH, DONE.
- IDLE: on `issue_valid & issue_ready`, latch op, hint and PC.
  - `INVALID_OP_2B`: go to DONE with `ine_exc` set.
  - Otherwise: go to DRAIN.
- DRAIN: wait until `sb_empty` and the outstanding count is 0, both sampled in the same cycle.
  - DBAR: go to DONE.
  - IBAR: go to FLUSH.
- FLUSH: `flush_req` held high until `flush_ack` is seen, then go to DONE. A `flush_ack` while not in FLUSH is ignored.
- DONE: `done` pulses. `redirect_valid` pulses for IBAR only. `ine_exc` pulses for the invalid op only. Then go to IDLE.
- Outstanding counter: runs in every state, including IDLE.
  - +1 on `ld_req_fire` alone; -1 on `ld_resp_fire` alone; no change when both fire.
  - Decrement at 0 holds 0; increment at max holds max. Both cases are covered by simulation assertions.
- `redirect_pc` = latched PC + 4, mod 2^32; wraps from 0xFFFFFFFC to 0x00000000.
- Reset in any state returns to IDLE and clears the counter and the latches. A pending flush is abandoned: `flush_req` drops the cycle after `rst`.

## Timing

- Reset values: `issue_ready`=1; `stall`, `flush_req`, `done`, `redirect_valid`, `ine_exc`=0; `redirect_pc`=0; count=0.
- All outputs are registered or decoded from state; there is no combinational input-to-output path.
- Accept at cycle T gives state DRAIN at T+1. With memory already drained at T+1, a DBAR pulses `done` at T+2 (minimum latency 2).
- IBAR minimum: `flush_req` rises at T+2. With `flush_ack` at cycle F, `done` and `redirect_valid` pulse at F+1.
- Invalid op: `done` and `ine_exc` pulse at T+1.
- `stall` is high from T+1 through the DONE cycle. `issue_ready` returns high the cycle after DONE.
- The DRAIN condition uses the registered count. A response at cycle C is counted as drained from C+1.

## Configuration

- Macro: `BAR_HINT_EN`.
  - Defined: a DBAR with `bar_hint[0]`=1 is a store-only barrier; DRAIN waits on `sb_empty` alone and ignores the load count.
  - Undefined: the hint is ignored and every DBAR is a full barrier. IBAR always ignores the hint.

## Structure

- `bar_pkg`: state enum (`BAR_IDLE`, `BAR_DRAIN`, `BAR_FLUSH`, `BAR_DONE`) and the hint bit-index constant. Op encodings stay in `defs.sv`.
- Sub-module `bar_outst_ctr`: the saturating up/down counter, parameterised by `OUTST_W`, with a `zero` output.

## Test plan

- DBAR with `sb_empty`=1 and count 0, accepted at T → `done` at T+2; no `flush_req`, no `redirect_valid`.
- Three loads outstanding, `sb_empty`=0; responses at C1, C2, C3, store buffer empties at C2 → `done` at C3+2. Same-cycle req+resp leaves the count unchanged.
- IBAR at PC 0x1C000100, `flush_ack` 5 cycles after `flush_req` rises → `done` and `redirect_valid` pulse together, `redirect_pc`=0x1C000104. IBAR at PC 0xFFFFFFFC → `redirect_pc`=0.
- `INVALID_OP_2B` with `issue_valid` at T → `ine_exc` and `done` at T+1, `issue_ready` high at T+2.
- `rst` asserted in FLUSH → next cycle IDLE, `flush_req`=0, `stall`=0, count=0; a later `flush_ack` has no effect.
- With `BAR_HINT_EN`: DBAR hint=1, 2 loads outstanding, `sb_empty`=1 → `done` at T+2. Without the macro, `done` waits for both responses.

Source files
------------

// File: rtl/bar_pkg.sv
// rtl/bar_pkg.sv - barrier engine state encoding and hint field layout
package bar_pkg;

    typedef enum logic [1:0] {
        BAR_IDLE  = 2'd0,
        BAR_DRAIN = 2'd1,
        BAR_FLUSH = 2'd2,
        BAR_DONE  = 2'd3
    } bar_state_e;

    localparam int BAR_HINT_STORE_ONLY_BIT = 0;

endpackage

// File: rtl/defs.sv
// rtl/defs.sv - shared decode encodings for barrier operations
package defs_pkg;

    localparam logic [1:0] BAR_DBAR      = 2'b00;
    localparam logic [1:0] BAR_IBAR      = 2'b01;
    localparam logic [1:0] INVALID_OP_2B = 2'b11;

endpackage

// File: rtl/bar_outst_ctr.sv
// rtl/bar_outst_ctr.sv - saturating up/down count of loads in flight
module bar_outst_ctr #(
    parameter int OUTST_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero
);

    localparam logic [OUTST_W-1:0] CNT_MAX = '1;
    localparam logic [OUTST_W-1:0] CNT_ONE = {{(OUTST_W-1){1'b0}}, 1'b1};

    logic [OUTST_W-1:0] cnt_q;
    logic [OUTST_W-1:0] cnt_d;

    // Simultaneous request and response cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

    a_dec_at_zero_holds: assert property (
        @(posedge clk) disable iff (rst)
        ((cnt_q == '0) && dec && !inc) |=> (cnt_q == '0)
    );

    a_inc_at_max_holds: assert property (
        @(posedge clk) disable iff (rst)
        ((cnt_q == CNT_MAX) && inc && !dec) |=> (cnt_q == CNT_MAX)
    );

endmodule

// File: rtl/bar_unit.sv
// rtl/bar_unit.sv - DBAR/IBAR barrier engine; BAR_HINT_EN enables store-only DBAR hint
module bar_unit
    import defs_pkg::*;
    import bar_pkg::*;
#(
    parameter int OUTST_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  bar_op_type,
    input  logic [14:0] bar_hint,
    input  logic [31:0] bar_pc,
    input  logic        ld_req_fire,
    input  logic        ld_resp_fire,
    input  logic        sb_empty,
    output logic        flush_req,
    input  logic        flush_ack,
    output logic        stall,
    output logic        done,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        ine_exc
);

    bar_state_e  state_q;
    bar_state_e  state_d;
    logic [1:0]  op_q;
    logic [1:0]  op_d;
    logic [14:0] hint_q;
    logic [14:0] hint_d;
    logic [31:0] redirect_pc_q;
    logic [31:0] redirect_pc_d;

    logic cnt_zero;
    logic store_only;
    logic drained;
    logic op_is_ibar;
    logic op_is_valid;
    logic hint_unused;

    bar_outst_ctr #(
        .OUTST_W(OUTST_W)
    ) u_outst_ctr (
        .clk  (clk),
        .rst  (rst),
        .inc  (ld_req_fire),
        .dec  (ld_resp_fire),
        .zero (cnt_zero)
    );

    assign hint_unused = ^hint_q;
    assign op_is_ibar  = (op_q == BAR_IBAR);
    assign op_is_valid = (op_q == BAR_DBAR) || (op_q == BAR_IBAR);

`ifdef BAR_HINT_EN
    assign store_only = (op_q == BAR_DBAR) && hint_q[BAR_HINT_STORE_ONLY_BIT];
`else
    assign store_only = 1'b0;
`endif

    // Registered count only: a response this cycle is seen as drained next cycle.
    assign drained = sb_empty && (cnt_zero || store_only);

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        hint_d        = hint_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            BAR_IDLE: begin
                if (issue_valid) begin
                    op_d          = bar_op_type;
                    hint_d        = bar_hint;
                    redirect_pc_d = bar_pc + 32'd4;
                    if ((bar_op_type == BAR_DBAR) || (bar_op_type == BAR_IBAR)) begin
                        state_d = BAR_DRAIN;
                    end else begin
                        state_d = BAR_DONE;
                    end
                end
            end
            BAR_DRAIN: begin
                if (drained) begin
                    state_d = op_is_ibar ? BAR_FLUSH : BAR_DONE;
                end
            end
            BAR_FLUSH: begin
                if (flush_ack) begin
                    state_d = BAR_DONE;
                end
            end
            BAR_DONE: begin
                state_d = BAR_IDLE;
            end
            default: begin
                state_d = BAR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BAR_IDLE;
            op_q          <= BAR_DBAR;
            hint_q        <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            hint_q        <= hint_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign issue_ready    = (state_q == BAR_IDLE);
    assign stall          = (state_q != BAR_IDLE);
    assign flush_req      = (state_q == BAR_FLUSH);
    assign done           = (state_q == BAR_DONE);
    assign redirect_valid = (state_q == BAR_DONE) && op_is_ibar;
    assign ine_exc        = (state_q == BAR_DONE) && !op_is_valid;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_bar_unit.sv
// tb/tb_bar_unit.sv - scoreboard bench for bar_unit
module tb_bar_unit;
    import defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [1:0]  bar_op_type;
    logic [14:0] bar_hint;
    logic [31:0] bar_pc;
    logic        ld_req_fire;
    logic        ld_resp_fire;
    logic        sb_empty;
    logic        flush_req;
    logic        flush_ack;
    logic        stall;
    logic        done;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ine_exc;

    typedef struct {
        int          cyc;
        logic        rv;
        logic        ine;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    bar_unit #(.OUTST_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .bar_op_type    (bar_op_type),
        .bar_hint       (bar_hint),
        .bar_pc         (bar_pc),
        .ld_req_fire    (ld_req_fire),
        .ld_resp_fire   (ld_resp_fire),
        .sb_empty       (sb_empty),
        .flush_req      (flush_req),
        .flush_ack      (flush_ack),
        .stall          (stall),
        .done           (done),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ine_exc        (ine_exc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Retirement monitor: every done pulse must match the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done cyc=%0d rv=%b ine=%b", cyc, redirect_valid, ine_exc);
                end else begin
                    e = sb_q.pop_front();
                    if (cyc !== e.cyc || redirect_valid !== e.rv || ine_exc !== e.ine ||
                        (e.rv && redirect_pc !== e.rpc)) begin
                        failures++;
                        $display("FAIL done_event got cyc=%0d rv=%b ine=%b rpc=%h expected cyc=%0d rv=%b ine=%b rpc=%h",
                                 cyc, redirect_valid, ine_exc, redirect_pc, e.cyc, e.rv, e.ine, e.rpc);
                    end
                end
            end else if (redirect_valid || ine_exc) begin
                checks++;
                failures++;
                $display("FAIL stray_pulse cyc=%0d rv=%b ine=%b expected 0 0", cyc, redirect_valid, ine_exc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d expected finish", cyc);
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int c, input logic rv, input logic ine, input logic [31:0] rpc);
        exp_t e;
        e.cyc = c;
        e.rv  = rv;
        e.ine = ine;
        e.rpc = rpc;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [14:0] hint, input logic [31:0] pc);
        issue_valid = 1'b1;
        bar_op_type = op;
        bar_hint    = hint;
        bar_pc      = pc;
        @(negedge clk);
        issue_valid = 1'b0;
    endtask

    task automatic wait_retire(input string name);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout pending=%0d expected=0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue_valid = 1'b0; bar_op_type = BAR_DBAR; bar_hint = '0; bar_pc = '0;
        ld_req_fire = 1'b0; ld_resp_fire = 1'b0; sb_empty = 1'b1; flush_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({issue_ready, stall, flush_req, done, redirect_valid, ine_exc} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_flags got %b expected 100000",
                     {issue_ready, stall, flush_req, done, redirect_valid, ine_exc});
        end
        checks++;
        if (redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_redirect_pc got %h expected 00000000", redirect_pc);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dbar_min();
        push_exp(cyc + 2, 1'b0, 1'b0, 32'h0);
        issue(BAR_DBAR, 15'h0, 32'h0000_1000);
        checks++;
        if (stall !== 1'b1 || issue_ready !== 1'b0 || flush_req !== 1'b0) begin
            failures++;
            $display("FAIL dbar_t1 got stall=%b ready=%b flush=%b expected 1 0 0", stall, issue_ready, flush_req);
        end
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || flush_req !== 1'b0) begin
            failures++;
            $display("FAIL dbar_t2 got stall=%b flush=%b expected 1 0", stall, flush_req);
        end
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL dbar_t3 got ready=%b stall=%b expected 1 0", issue_ready, stall);
        end
        wait_retire("dbar_min");
    endtask

    task automatic test_loads();
        sb_empty = 1'b0;
        ld_req_fire = 1'b1;
        repeat (3) @(negedge clk);
        ld_resp_fire = 1'b1;
        @(negedge clk);
        ld_req_fire = 1'b0;
        ld_resp_fire = 1'b0;
        // Responses at T+2, T+4, T+6; store buffer empties at T+4.
        push_exp(cyc + 8, 1'b0, 1'b0, 32'h0);
        issue(BAR_DBAR, 15'h0, 32'h0000_2000);
        for (int k = 1; k <= 8; k++) begin
            ld_resp_fire = (k == 2 || k == 4 || k == 6);
            if (k >= 4) sb_empty = 1'b1;
            @(negedge clk);
        end
        ld_resp_fire = 1'b0;
        wait_retire("loads");
    endtask

    task automatic test_ibar(input logic [31:0] pc, input logic [31:0] exp_rpc);
        int t;
        int k;
        logic held;
        t = cyc;
        issue(BAR_IBAR, 15'h0, pc);
        k = 0;
        while (!flush_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (flush_req !== 1'b1 || cyc != t + 2) begin
            failures++;
            $display("FAIL ibar_flush_rise got flush=%b cyc=%0d expected 1 cyc=%0d", flush_req, cyc, t + 2);
        end
        held = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (flush_req !== 1'b1) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            failures++;
            $display("FAIL ibar_flush_hold got %b expected 1", held);
        end
        flush_ack = 1'b1;
        push_exp(cyc + 1, 1'b1, 1'b0, exp_rpc);
        @(negedge clk);
        flush_ack = 1'b0;
        checks++;
        if (flush_req !== 1'b0) begin
            failures++;
            $display("FAIL ibar_flush_drop got %b expected 0", flush_req);
        end
        wait_retire("ibar");
    endtask

    task automatic test_invalid();
        push_exp(cyc + 1, 1'b0, 1'b1, 32'h0);
        issue(INVALID_OP_2B, 15'h0, 32'h0000_3000);
        checks++;
        if (stall !== 1'b1 || issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL invalid_t1 got stall=%b ready=%b expected 1 0", stall, issue_ready);
        end
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL invalid_ready got %b expected 1", issue_ready);
        end
        wait_retire("invalid");
    endtask

    task automatic test_reset_in_flush();
        int k;
        logic quiet;
        issue(BAR_IBAR, 15'h0, 32'h0000_4000);
        k = 0;
        while (!flush_req && k < 10) begin
            @(negedge clk);
            k++;
        end
        ld_req_fire = 1'b1;
        repeat (2) @(negedge clk);
        ld_req_fire = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (flush_req !== 1'b0 || stall !== 1'b0 || issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_flush got flush=%b stall=%b ready=%b expected 0 0 1", flush_req, stall, issue_ready);
        end
        flush_ack = 1'b1;
        @(negedge clk);
        flush_ack = 1'b0;
        quiet = 1'b1;
        repeat (3) begin
            if (flush_req !== 1'b0 || stall !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL late_ack_effect got quiet=%b expected 1", quiet);
        end
        // A cleared counter lets a fresh DBAR retire at minimum latency.
        push_exp(cyc + 2, 1'b0, 1'b0, 32'h0);
        issue(BAR_DBAR, 15'h0, 32'h0000_5000);
        wait_retire("rst_count");
    endtask

    task automatic test_back_to_back();
        push_exp(cyc + 2, 1'b0, 1'b0, 32'h0);
        push_exp(cyc + 5, 1'b0, 1'b0, 32'h0);
        issue_valid = 1'b1;
        bar_op_type = BAR_DBAR;
        bar_hint    = 15'h0;
        bar_pc      = 32'h0000_6000;
        @(negedge clk);
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy got %b expected 0", issue_ready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_reaccept got %b expected 1", issue_ready);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        wait_retire("b2b");
    endtask

    task automatic test_hint();
        sb_empty = 1'b1;
        ld_req_fire = 1'b1;
        repeat (2) @(negedge clk);
        ld_req_fire = 1'b0;
`ifdef BAR_HINT_EN
        push_exp(cyc + 2, 1'b0, 1'b0, 32'h0);
`else
        push_exp(cyc + 7, 1'b0, 1'b0, 32'h0);
`endif
        issue(BAR_DBAR, 15'h1, 32'h0000_7000);
        for (int k = 1; k <= 6; k++) begin
            ld_resp_fire = (k == 3 || k == 5);
            @(negedge clk);
        end
        ld_resp_fire = 1'b0;
        wait_retire("hint");
    endtask

    initial begin
        test_reset();
        test_dbar_min();
        test_loads();
        test_ibar(32'h1C00_0100, 32'h1C00_0104);
        test_ibar(32'hFFFF_FFFC, 32'h0000_0000);
        test_invalid();
        test_reset_in_flush();
        test_back_to_back();
        test_hint();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
